// File: rtl/hazard_ctrl_pkg.sv
// Shared core definitions for the ID-stage hazard control block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Datapath width; also the width of the stall counter.
  localparam int XLEN = 32;

  // Architectural register address width (2^HC_REG_AW registers).
  localparam int HC_REG_AW = 5;

  // Wide enough for a flush length up to 15 cycles.
  localparam int HC_FLUSH_CNT_W = 4;

  typedef enum logic [0:0] {
    HC_IDLE  = 1'b0,
    HC_FLUSH = 1'b1
  } hc_state_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one bit per register, plus the RAW/WAW compare.
// Latency: hazard is combinational from registered pending bits; updates land at the clock edge.
// Backpressure: none; hazard is consumed by hazard_ctrl to form the ID stall.
//
// Ports:
//   clk, rst_b                    clock, async active-low reset
//   id_valid, id_rs*_read/addr    ID source operands
//   id_rd_write, id_rd_addr       ID destination operand
//   set_en                        issue qualified by the controller; sets pending[id_rd_addr]
//   wb_rd_write, wb_rd_addr       writeback; clears pending[wb_rd_addr]
//   hazard                        ID instruction touches a register with a write in flight
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW = HC_REG_AW
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              id_valid,
  input  logic              id_rs1_read,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic              id_rs2_read,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rd_write,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              set_en,
  input  logic              wb_rd_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  output logic              hazard
);

  localparam int NREG = 1 << REG_AW;

  // Register 0 is hardwired, so it has no pending bit at all.
  logic [NREG-1:1] pending;
  logic [NREG-1:0] pend_full;

  // Zero-extended view so any address (including 0) can index directly.
  assign pend_full = {pending, 1'b0};

  // Only registered pending is consulted: a writeback clear becomes
  // visible to ID one cycle later, never in the same cycle.
  assign hazard = id_valid & ((id_rs1_read & pend_full[id_rs1_addr]) |
                              (id_rs2_read & pend_full[id_rs2_addr]) |
                              (id_rd_write & pend_full[id_rd_addr]));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      pending <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        // A new issue to a register outranks a writeback of its older value.
        if (set_en && (id_rd_addr == REG_AW'(i))) begin
          pending[i] <= 1'b1;
        end else if (wb_rd_write && (wb_rd_addr == REG_AW'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: scoreboard stall, redirect kill FSM, stall counter.
// Latency: id_stall/id_kill are combinational from inputs and registered state.
// Backpressure: id_stall holds the ID->EX handshake; id_kill discards IF/ID contents.
//
// Ports:
//   clk, rst_b                         clock, async active-low reset
//   id_valid, id_rs1/rs2_read/addr     ID instruction sources
//   id_rd_write, id_rd_addr            ID instruction destination
//   id_issue                           ID->EX handshake fires this cycle
//   wb_rd_write, wb_rd_addr            register-file writeback
//   ex_flush                           single-cycle redirect from EX
//   id_stall, id_kill                  ID control outputs
//   stall_cnt                          saturating count of stalled valid ID cycles
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW       = HC_REG_AW,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              id_valid,
  input  logic              id_rs1_read,
  input  logic              id_rs2_read,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_rd_write,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_issue,
  input  logic              wb_rd_write,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic              ex_flush,
  output logic              id_stall,
  output logic              id_kill,
  output logic [XLEN-1:0]   stall_cnt
);

  localparam logic [HC_FLUSH_CNT_W-1:0] FLUSH_LOAD = HC_FLUSH_CNT_W'(FLUSH_CYCLES - 1);

  hc_state_t                 state, state_nxt;
  logic [HC_FLUSH_CNT_W-1:0] flush_cnt, flush_cnt_nxt;
  logic                      hazard;
  logic                      set_en;

  // Killed or stalled instructions never issue, so they must not mark rd.
  assign set_en = id_issue & id_rd_write & (id_rd_addr != '0) & ~id_stall;

  hazard_scoreboard #(
    .REG_AW (REG_AW)
  ) u_sb (
    .clk         (clk),
    .rst_b       (rst_b),
    .id_valid    (id_valid),
    .id_rs1_read (id_rs1_read),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_read (id_rs2_read),
    .id_rs2_addr (id_rs2_addr),
    .id_rd_write (id_rd_write),
    .id_rd_addr  (id_rd_addr),
    .set_en      (set_en),
    .wb_rd_write (wb_rd_write),
    .wb_rd_addr  (wb_rd_addr),
    .hazard      (hazard)
  );

  assign id_kill  = ex_flush | (state == HC_FLUSH);
  assign id_stall = hazard | id_kill;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= HC_IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  // flush_cnt holds the number of FLUSH cycles still to come, the current
  // one included. The pulse cycle kills by itself, so the total kill window
  // is FLUSH_CYCLES: the pulse plus FLUSH_CYCLES-1 cycles in FLUSH. With
  // FLUSH_CYCLES==1 the FSM never leaves IDLE.
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    unique case (state)
      HC_IDLE: begin
        if (ex_flush && (FLUSH_LOAD != '0)) begin
          state_nxt     = HC_FLUSH;
          flush_cnt_nxt = FLUSH_LOAD;
        end
      end
      HC_FLUSH: begin
        if (ex_flush) begin
          flush_cnt_nxt = FLUSH_LOAD;
          if (FLUSH_LOAD == '0) begin
            state_nxt = HC_IDLE;
          end
        end else if (flush_cnt <= HC_FLUSH_CNT_W'(1)) begin
          flush_cnt_nxt = '0;
          state_nxt     = HC_IDLE;
        end else begin
          flush_cnt_nxt = flush_cnt - 1'b1;
        end
      end
      default: begin
        state_nxt     = HC_IDLE;
        flush_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stall_cnt <= '0;
    end else if (id_valid && id_stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_b;
  logic        id_valid;
  logic        id_rs1_read;
  logic        id_rs2_read;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic        id_rd_write;
  logic [4:0]  id_rd_addr;
  logic        id_issue;
  logic        wb_rd_write;
  logic [4:0]  wb_rd_addr;
  logic        ex_flush;
  logic        id_stall;
  logic        id_kill;
  logic [31:0] stall_cnt;

  int n_checks;
  int n_fail;

  hazard_ctrl #(
    .REG_AW       (5),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .id_valid    (id_valid),
    .id_rs1_read (id_rs1_read),
    .id_rs2_read (id_rs2_read),
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rd_write (id_rd_write),
    .id_rd_addr  (id_rd_addr),
    .id_issue    (id_issue),
    .wb_rd_write (wb_rd_write),
    .wb_rd_addr  (wb_rd_addr),
    .ex_flush    (ex_flush),
    .id_stall    (id_stall),
    .id_kill     (id_kill),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs are driven there.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid    = 1'b0;
    id_rs1_read = 1'b0;
    id_rs2_read = 1'b0;
    id_rs1_addr = '0;
    id_rs2_addr = '0;
    id_rd_write = 1'b0;
    id_rd_addr  = '0;
    id_issue    = 1'b0;
    wb_rd_write = 1'b0;
    wb_rd_addr  = '0;
    ex_flush    = 1'b0;
  endtask

  // ID holds an instruction that issues and writes rd.
  task automatic drive_issue(input logic [4:0] rd);
    idle_inputs();
    id_valid    = 1'b1;
    id_rd_write = 1'b1;
    id_rd_addr  = rd;
    id_issue    = 1'b1;
  endtask

  // ID holds an instruction that only reads rs1 and does not issue.
  task automatic drive_read1(input logic [4:0] rs);
    idle_inputs();
    id_valid    = 1'b1;
    id_rs1_read = 1'b1;
    id_rs1_addr = rs;
  endtask

  task automatic drive_wb(input logic [4:0] rd);
    idle_inputs();
    wb_rd_write = 1'b1;
    wb_rd_addr  = rd;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_b = 1'b0;
    #3;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", id_stall); end
    n_checks++;
    if (id_kill !== 1'b0) begin n_fail++; $display("FAIL reset_kill got=%b exp=0", id_kill); end
    n_checks++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got=%h exp=0", stall_cnt); end
    cyc();
    cyc();
    rst_b = 1'b1;
  endtask

  task automatic test_raw();
    cyc();
    drive_issue(5'd5);
    #2;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL raw_issue_stall got=%b exp=0", id_stall); end
    cyc();
    drive_read1(5'd5);
    #2;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall1 got=%b exp=1", id_stall); end
    cyc();
    #2;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL raw_stall2 got=%b exp=1", id_stall); end
    cyc();
    drive_read1(5'd5);
    wb_rd_write = 1'b1;
    wb_rd_addr  = 5'd5;
    #2;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL raw_wb_cycle got=%b exp=1", id_stall); end
    cyc();
    drive_read1(5'd5);
    #2;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL raw_release got=%b exp=0", id_stall); end
    n_checks++;
    if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL raw_cnt got=%0d exp=3", stall_cnt); end
    id_issue = 1'b1;
  endtask

  task automatic test_x0();
    cyc();
    drive_issue(5'd0);
    #2;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL x0_issue got=%b exp=0", id_stall); end
    cyc();
    idle_inputs();
    id_valid    = 1'b1;
    id_rs1_read = 1'b1;
    id_rs2_read = 1'b1;
    id_rd_write = 1'b1;
    #2;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL x0_read got=%b exp=0", id_stall); end
    n_checks++;
    if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL x0_cnt got=%0d exp=3", stall_cnt); end
  endtask

  task automatic test_waw();
    cyc();
    drive_issue(5'd7);
    cyc();
    idle_inputs();
    id_valid    = 1'b1;
    id_rd_write = 1'b1;
    id_rd_addr  = 5'd7;
    #2;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall got=%b exp=1", id_stall); end
    cyc();
    wb_rd_write = 1'b1;
    wb_rd_addr  = 5'd7;
    #2;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL waw_wb_cycle got=%b exp=1", id_stall); end
    cyc();
    wb_rd_write = 1'b0;
    id_issue    = 1'b1;
    #2;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL waw_issue got=%b exp=0", id_stall); end
    cyc();
    drive_read1(5'd7);
    #2;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL waw_reset7 got=%b exp=1", id_stall); end
    // Issue to 9 and writeback of 9 in the same cycle: the issue must win.
    cyc();
    drive_issue(5'd9);
    wb_rd_write = 1'b1;
    wb_rd_addr  = 5'd9;
    cyc();
    idle_inputs();
    id_valid    = 1'b1;
    id_rs2_read = 1'b1;
    id_rs2_addr = 5'd9;
    #2;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL set_wins got=%b exp=1", id_stall); end
    cyc();
    drive_wb(5'd7);
    cyc();
    drive_wb(5'd9);
    cyc();
    idle_inputs();
    id_valid    = 1'b1;
    id_rs1_read = 1'b1;
    id_rs1_addr = 5'd7;
    id_rs2_read = 1'b1;
    id_rs2_addr = 5'd9;
    #2;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL waw_cleared got=%b exp=0", id_stall); end
  endtask

  task automatic test_flush();
    cyc();
    drive_issue(5'd4);
    cyc();
    // Issue attempt to 6 during the kill window must not mark 6.
    drive_issue(5'd6);
    ex_flush = 1'b1;
    #2;
    n_checks++;
    if (id_kill !== 1'b1) begin n_fail++; $display("FAIL flush_pulse_kill got=%b exp=1", id_kill); end
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL flush_pulse_stall got=%b exp=1", id_stall); end
    cyc();
    ex_flush = 1'b0;
    #2;
    n_checks++;
    if (id_kill !== 1'b1) begin n_fail++; $display("FAIL flush_second got=%b exp=1", id_kill); end
    cyc();
    idle_inputs();
    #2;
    n_checks++;
    if (id_kill !== 1'b0) begin n_fail++; $display("FAIL flush_end got=%b exp=0", id_kill); end
    // Pulse, then a second pulse while in FLUSH.
    cyc();
    ex_flush = 1'b1;
    cyc();
    ex_flush = 1'b1;
    #2;
    n_checks++;
    if (id_kill !== 1'b1) begin n_fail++; $display("FAIL reflush_pulse got=%b exp=1", id_kill); end
    cyc();
    ex_flush = 1'b0;
    #2;
    n_checks++;
    if (id_kill !== 1'b1) begin n_fail++; $display("FAIL reflush_extend got=%b exp=1", id_kill); end
    cyc();
    #2;
    n_checks++;
    if (id_kill !== 1'b0) begin n_fail++; $display("FAIL reflush_end got=%b exp=0", id_kill); end
    drive_read1(5'd4);
    #1;
    n_checks++;
    if (id_stall !== 1'b1) begin n_fail++; $display("FAIL flush_keeps_4 got=%b exp=1", id_stall); end
    drive_read1(5'd6);
    #1;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL flush_no_set_6 got=%b exp=0", id_stall); end
    cyc();
    drive_wb(5'd4);
    cyc();
    idle_inputs();
  endtask

  task automatic test_saturation();
    cyc();
    drive_issue(5'd12);
    cyc();
    drive_read1(5'd12);
    force dut.stall_cnt = 32'hFFFF_FFFD;
    #1;
    release dut.stall_cnt;
    cyc();
    #2;
    n_checks++;
    if (stall_cnt !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL sat_fe got=%h exp=fffffffe", stall_cnt); end
    cyc();
    #2;
    n_checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_ff got=%h exp=ffffffff", stall_cnt); end
    cyc();
    cyc();
    #2;
    n_checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_hold got=%h exp=ffffffff", stall_cnt); end
    cyc();
    drive_wb(5'd12);
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    cyc();
    drive_issue(5'd3);
    cyc();
    drive_issue(5'd9);
    cyc();
    idle_inputs();
    ex_flush = 1'b1;
    cyc();
    idle_inputs();
    id_valid    = 1'b1;
    id_rs1_read = 1'b1;
    id_rs1_addr = 5'd3;
    id_rs2_read = 1'b1;
    id_rs2_addr = 5'd9;
    #2;
    n_checks++;
    if (id_kill !== 1'b1) begin n_fail++; $display("FAIL mid_pre_kill got=%b exp=1", id_kill); end
    n_checks++;
    if (stall_cnt === 32'd0) begin n_fail++; $display("FAIL mid_pre_cnt got=%h exp=nonzero", stall_cnt); end
    // Assert reset away from any clock edge.
    rst_b = 1'b0;
    #1;
    n_checks++;
    if (id_kill !== 1'b0) begin n_fail++; $display("FAIL mid_kill got=%b exp=0", id_kill); end
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL mid_stall got=%b exp=0", id_stall); end
    n_checks++;
    if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_cnt got=%h exp=0", stall_cnt); end
    cyc();
    rst_b = 1'b1;
    cyc();
    #2;
    n_checks++;
    if (id_stall !== 1'b0) begin n_fail++; $display("FAIL mid_after got=%b exp=0", id_stall); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_b    = 1'b0;
    idle_inputs();
    test_reset();
    test_raw();
    test_x0();
    test_waw();
    test_flush();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
